// File: rtl/seq_controle.sv
// Purpose : command-driven sequencer for the A/B register + ALU datapath (load A, load B, iterate ALU op into A).
// Latency : start sampled in cycle 0, done pulses in cycle 3+iter; strobes are Mealy on (state, adv, abort).
// Backpress: no handshake; start is only accepted in IDLE, abort cancels any sequence immediately.
//
// Ports:
//   clk, reset (async, active-low)
//   start, cmd[1:0], iter[CNT_W-1:0] : request, latched when start is accepted in IDLE
//   abort                            : cancel current sequence (ignored in IDLE, beats start)
//   tick                             : pacing strobe, only used when SEQ_TICK_EN is defined
//   selA, wrA, wrB, aluOp[1:0]       : datapath controls
//   busy, done                       : status (busy = not IDLE, done = one-cycle completion pulse)
//   prStateLed, nxStateLed           : present / next state code for board LEDs
//
// Optional feature macro: SEQ_TICK_EN -- LOADA/LOADB/EXEC advance only on tick=1.

module seq_controle #(
  parameter int          CNT_W   = 4,
  parameter logic [1:0]  IDLE_OP = 2'b00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       cmd,
  input  logic [CNT_W-1:0] iter,
  input  logic             abort,
  input  logic             tick,
  output logic             selA,
  output logic             wrA,
  output logic             wrB,
  output logic [1:0]       aluOp,
  output logic             busy,
  output logic             done,
  output logic [2:0]       prStateLed,
  output logic [2:0]       nxStateLed
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_LOADA = 3'b001,
    S_LOADB = 3'b010,
    S_EXEC  = 3'b011,
    S_DONE  = 3'b101
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [1:0]       cmd_q, cmd_d;
  logic             adv;

`ifdef SEQ_TICK_EN
  assign adv = tick;
`else
  // tick is kept on the port list so both builds share one pinout.
  logic unused_tick;
  assign unused_tick = tick;
  assign adv         = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cmd_d   = cmd_q;
    wrA     = 1'b0;
    wrB     = 1'b0;
    selA    = 1'b0;
    aluOp   = IDLE_OP;
    done    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Abort beats a simultaneous start; IDLE->LOADA is never tick-gated.
        if (start && !abort) begin
          state_d = S_LOADA;
          rem_d   = iter;
          cmd_d   = cmd;
        end
      end
      S_LOADA: begin
        if (adv) begin
          wrA     = 1'b1;
          state_d = S_LOADB;
        end
      end
      S_LOADB: begin
        if (adv) begin
          wrB     = 1'b1;
          state_d = (rem_q != '0) ? S_EXEC : S_DONE;
        end
      end
      S_EXEC: begin
        // aluOp follows the latched command on held cycles too, so the
        // ALU output is stable while waiting for the next tick.
        aluOp = cmd_q;
        if (adv) begin
          wrA   = 1'b1;
          selA  = 1'b1;
          rem_d = rem_q - 1'b1;
          if (rem_q == CNT_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        // Illegal codes 100/110/111 recover to IDLE.
        state_d = S_IDLE;
      end
    endcase

    // Abort outside IDLE: squash this cycle's strobes and the done pulse.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      rem_d   = rem_q;
      wrA     = 1'b0;
      wrB     = 1'b0;
      selA    = 1'b0;
      done    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      cmd_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cmd_q   <= cmd_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign prStateLed = state_q;
  assign nxStateLed = state_d;

endmodule
